rv32i_instruction_encoder: RTL and testbench
============================================

Name: rv32i_instruction_encoder

Overview:
Inverse of the core's instruction decoder. Accepts decoded RV32I fields and emits 32-bit instruction words. Used by the debug/boot instruction injector to build instructions in hardware. Supports OP, OP-IMM, LUI, BRANCH, JAL and JALR. Valid/ready on both sides, with a 2-entry output FIFO.

Parameters:
COUNT_WIDTH, 16, width of the EncodedCount counter
ERR_WIDTH, 8, width of the saturating ErrorCount counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
InValid  input  1  input fields valid
InReady  output  1  encoder can accept
Format  input  3  0=OP 1=OPI 2=LUI 3=BRANCH 4=JAL 5=JALR; 6,7 invalid
Funct3  input  3  funct3 field
AltBit  input  1  instruction bit 30 (SUB/SRA/SRAI)
RD  input  5  destination register
RS1  input  5  source register 1
RS2  input  5  source register 2
Immediate  input  32  byte-offset / value, sign-extended form
OutValid  output  1  FIFO head valid
OutReady  input  1  consumer accepts head
Instruction  output  32  encoded word at FIFO head
OutError  output  1  head word was an encode error
EncodedCount  output  COUNT_WIDTH  words popped, wraps
ErrorCount  output  ERR_WIDTH  error words pushed, saturates

Behaviour:
- Reset (synchronous): FIFO count=0, OutValid=0, Instruction=0, OutError=0, EncodedCount=0, ErrorCount=0. InReady=0 while reset is high.
- InReady = !reset && (count != 2). Push on InValid&&InReady. Pop on OutValid&&OutReady.
- Encoding is combinational at push; the result is written to the FIFO tail. Latency: push in cycle N gives OutValid in cycle N+1 when the FIFO was empty.
- FIFO: 2 entries, strictly in order. Instruction and OutError are registered, from the head entry.
  - Push+pop with count=1: count stays 1, new word becomes head next cycle.
  - Push+pop with count=0: not possible (OutValid=0).
  - Count=2: InReady=0, so no push.
- Encodings:
  - OP: {0,AltBit,00000,RS2,RS1,Funct3,RD,0110011}. AltBit is legal only with Funct3 000 or 101.
  - OPI: {Immediate[11:0],RS1,Funct3,RD,0010011}.
    - Funct3=001: bits[31:25]=0000000.
    - Funct3=101: bits[31:25]={0,AltBit,00000}, bits[24:20]=Immediate[4:0].
    - AltBit with any other Funct3 is an error.
  - LUI: {Immediate[31:12],RD,0110111}. Funct3 and AltBit are ignored.
  - BRANCH: {Imm[12],Imm[10:5],RS2,RS1,Funct3,Imm[4:1],Imm[11],1100011}. Funct3 010 and 011 are errors.
  - JAL: {Imm[20],Imm[10:1],Imm[11],Imm[19:12],RD,1101111}.
  - JALR: {Imm[11:0],RS1,000,RD,1100111}. Funct3 must be 000, else error.
- Error: Format 6/7 or an illegal Funct3/AltBit combination. The word is forced to 32'h00000013 (NOP) with OutError=1. ErrorCount increments at push and saturates at all-ones.
- EncodedCount increments on every pop, error words included, and wraps.
- Reset mid-operation flushes the FIFO. Words not yet popped are lost.

Optional Feature:
Macro ENCODER_RANGE_CHECK_EN.
- Defined: the Immediate must be exactly representable, otherwise the push is an error (NOP, OutError=1).
  - OPI/JALR: Immediate must equal the sign-extension of [11:0].
  - Shift OPI: Immediate[31:5]=0.
  - LUI: Immediate[11:0]=0.
  - BRANCH: Immediate[0]=0 and Immediate must equal the sign-extension of [12:0].
  - JAL: Immediate[0]=0 and Immediate must equal the sign-extension of [20:0].
- Undefined: no checks. Unused Immediate bits are silently truncated.

Test Plan:
- ADDI x1,x0,5 (Format=1,F3=0,RD=1,RS1=0,Imm=5) -> Instruction=0x00500093, OutError=0, one cycle after push.
- SUB x3,x1,x2 (Format=0,Alt=1,F3=0) -> 0x402081B3. Then LUI x5 with Imm=0x12345000 -> 0x123452B7.
- BEQ x1,x2 with Imm=0xFFFFFFFC -> 0xFE208EE3. JAL x1 with Imm=8 -> 0x008000EF.
- Backpressure: OutReady=0, push 3 words -> InReady=0 after the 2nd push. Release -> words pop in order, EncodedCount=3 after the 3rd pop completes.
- Format=7 -> 0x00000013, OutError=1, ErrorCount=1. Push 300 errors -> ErrorCount stays 255.
- ADDI with Imm=0x800 -> with the macro: NOP and OutError=1. Without the macro: 0x80000093, OutError=0.

Source files
------------

// File: rtl/rv32i_instruction_encoder.sv
// rv32i_instruction_encoder
//   Builds RV32I instruction words from decoded fields (OP, OP-IMM, LUI,
//   BRANCH, JAL, JALR). Encoding is combinational at push; results go into
//   a 2-entry in-order FIFO whose head drives Instruction/OutError.
//   Illegal format/funct3/alt-bit combinations emit a NOP (0x00000013)
//   flagged by OutError.
//
//   Build option: define ENCODER_RANGE_CHECK_EN to also flag immediates that
//   do not fit the target format (otherwise excess bits are truncated).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   InValid/InReady   input handshake
//   Format, Funct3, AltBit, RD, RS1, RS2, Immediate   decoded fields
//   OutValid/OutReady output handshake (FIFO head)
//   Instruction       encoded word at head
//   OutError          head word is an encode error
//   EncodedCount      words popped (wrapping)
//   ErrorCount        error words pushed (saturating)
module rv32i_instruction_encoder #(
  parameter int COUNT_WIDTH = 16,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [2:0]             Format,
  input  logic [2:0]             Funct3,
  input  logic                   AltBit,
  input  logic [4:0]             RD,
  input  logic [4:0]             RS1,
  input  logic [4:0]             RS2,
  input  logic [31:0]            Immediate,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [31:0]            Instruction,
  output logic                   OutError,
  output logic [COUNT_WIDTH-1:0] EncodedCount,
  output logic [ERR_WIDTH-1:0]   ErrorCount
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } entry_t;

  entry_t     head_q, tail_q, enc;
  logic [1:0] count_q;
  logic       push, pop;
  logic [31:0] raw_word;
  logic        field_err, range_err;
  logic        is_shift;

  assign InReady  = !reset && (count_q != 2'd2);
  assign OutValid = (count_q != 2'd0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  assign Instruction = head_q.word;
  assign OutError    = head_q.err;

  // OP-IMM shifts carry a 5-bit shamt in place of the upper immediate
  assign is_shift = (Funct3 == 3'b001) || (Funct3 == 3'b101);

  always_comb begin
    raw_word  = NOP;
    field_err = 1'b0;
    case (Format)
      3'd0: begin // OP
        raw_word  = {1'b0, AltBit, 5'b0, RS2, RS1, Funct3, RD, 7'b0110011};
        field_err = AltBit && (Funct3 != 3'b000) && (Funct3 != 3'b101);
      end
      3'd1: begin // OP-IMM
        if (is_shift)
          raw_word = {1'b0, AltBit && (Funct3 == 3'b101), 5'b0, Immediate[4:0],
                      RS1, Funct3, RD, 7'b0010011};
        else
          raw_word = {Immediate[11:0], RS1, Funct3, RD, 7'b0010011};
        field_err = AltBit && (Funct3 != 3'b101);
      end
      3'd2: raw_word = {Immediate[31:12], RD, 7'b0110111}; // LUI
      3'd3: begin // BRANCH
        raw_word  = {Immediate[12], Immediate[10:5], RS2, RS1, Funct3,
                     Immediate[4:1], Immediate[11], 7'b1100011};
        field_err = (Funct3 == 3'b010) || (Funct3 == 3'b011);
      end
      3'd4: raw_word = {Immediate[20], Immediate[10:1], Immediate[11],
                        Immediate[19:12], RD, 7'b1101111}; // JAL
      3'd5: begin // JALR
        raw_word  = {Immediate[11:0], RS1, 3'b000, RD, 7'b1100111};
        field_err = (Funct3 != 3'b000);
      end
      default: field_err = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  always_comb begin
    range_err = 1'b0;
    case (Format)
      3'd1: range_err = is_shift ? (Immediate[31:5] != 27'd0)
                                 : (Immediate != {{20{Immediate[11]}}, Immediate[11:0]});
      3'd2: range_err = (Immediate[11:0] != 12'd0);
      3'd3: range_err = Immediate[0] ||
                        (Immediate != {{19{Immediate[12]}}, Immediate[12:0]});
      3'd4: range_err = Immediate[0] ||
                        (Immediate != {{11{Immediate[20]}}, Immediate[20:0]});
      3'd5: range_err = (Immediate != {{20{Immediate[11]}}, Immediate[11:0]});
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  always_comb begin
    enc.err  = field_err || range_err;
    enc.word = enc.err ? NOP : raw_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 2'd0;
      EncodedCount <= '0;
      ErrorCount   <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= enc;
          else                 tail_q <= enc;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // count stays; with one entry the new word becomes head directly
          if (count_q == 2'd1) head_q <= enc;
          else begin
            head_q <= tail_q;
            tail_q <= enc;
          end
        end
        default: ;
      endcase
      if (pop) EncodedCount <= EncodedCount + 1'b1;
      if (push && enc.err && (ErrorCount != '1)) ErrorCount <= ErrorCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_instruction_encoder.sv
module tb_rv32i_instruction_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        InValid, InReady;
  logic [2:0]  Format, Funct3;
  logic        AltBit;
  logic [4:0]  RD, RS1, RS2;
  logic [31:0] Immediate;
  logic        OutValid, OutReady;
  logic [31:0] Instruction;
  logic        OutError;
  logic [15:0] EncodedCount;
  logic [7:0]  ErrorCount;

  int total = 0;
  int bad   = 0;

  rv32i_instruction_encoder #(.COUNT_WIDTH(16), .ERR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .Format(Format), .Funct3(Funct3), .AltBit(AltBit), .RD(RD), .RS1(RS1),
    .RS2(RS2), .Immediate(Immediate), .OutValid(OutValid), .OutReady(OutReady),
    .Instruction(Instruction), .OutError(OutError),
    .EncodedCount(EncodedCount), .ErrorCount(ErrorCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    Format = f; Funct3 = f3; AltBit = alt; RD = rd; RS1 = rs1; RS2 = rs2; Immediate = imm;
  endtask

  // one cycle with optional push/pop; outputs sampled 1ns after the edge
  task automatic step(input logic do_push, input logic do_pop);
    @(negedge clk);
    InValid = do_push; OutReady = do_pop;
    @(posedge clk); #1;
    InValid = 1'b0; OutReady = 1'b0;
  endtask

  task automatic push(input logic [2:0] f, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    set_fields(f, f3, alt, rd, rs1, rs2, imm);
    step(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_outerr", {31'd0, OutError}, 32'd0);
    chk("rst_enccnt", {16'd0, EncodedCount}, 32'd0);
    chk("rst_errcnt", {24'd0, ErrorCount}, 32'd0);
    chk("rst_inready", {31'd0, InReady}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("inready_after_rst", {31'd0, InReady}, 32'd1);

    // ADDI x1,x0,5
    push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_valid", {31'd0, OutValid}, 32'd1);
    chk("addi_word", Instruction, 32'h0050_0093);
    chk("addi_err", {31'd0, OutError}, 32'd0);
    step(1'b0, 1'b1);
    chk("addi_popped", {31'd0, OutValid}, 32'd0);
    chk("enccnt_1", {16'd0, EncodedCount}, 32'd1);

    // SUB x3,x1,x2
    push(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("sub_word", Instruction, 32'h4020_81B3);
    step(1'b0, 1'b1);
    // LUI x5,0x12345
    push(3'd2, 3'd7, 1'b1, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    chk("lui_word", Instruction, 32'h1234_52B7);
    chk("lui_err", {31'd0, OutError}, 32'd0);
    step(1'b0, 1'b1);
    // BEQ x1,x2,-4
    push(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    chk("beq_word", Instruction, 32'hFE20_8EE3);
    step(1'b0, 1'b1);
    // JAL x1,8
    push(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    chk("jal_word", Instruction, 32'h0080_00EF);
    step(1'b0, 1'b1);
    chk("enccnt_5", {16'd0, EncodedCount}, 32'd5);

    // Backpressure: two words fill the FIFO, third waits for space
    push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    chk("bp_inready_1", {31'd0, InReady}, 32'd1);
    push(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    chk("bp_inready_full", {31'd0, InReady}, 32'd0);
    chk("bp_head_a", Instruction, 32'h0010_0093);
    step(1'b0, 1'b1);
    chk("bp_head_b", Instruction, 32'h0020_0113);
    chk("bp_inready_2", {31'd0, InReady}, 32'd1);
    push(3'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
    step(1'b0, 1'b1);
    chk("bp_head_c", Instruction, 32'h0030_0193);
    step(1'b0, 1'b1);
    chk("bp_empty", {31'd0, OutValid}, 32'd0);
    chk("bp_enccnt", {16'd0, EncodedCount}, 32'd8); // 5 earlier + 3

    // Simultaneous push+pop with one entry: new word becomes head
    push(3'd1, 3'd0, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4);
    chk("pp_head_d", Instruction, 32'h0040_0213);
    @(negedge clk);
    set_fields(3'd1, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd5);
    step(1'b1, 1'b1);
    chk("pp_head_e", Instruction, 32'h0050_0293);
    chk("pp_valid", {31'd0, OutValid}, 32'd1);
    chk("pp_inready", {31'd0, InReady}, 32'd1);
    step(1'b0, 1'b1);
    chk("pp_empty", {31'd0, OutValid}, 32'd0);

    // Error cases
    push(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    chk("fmt7_word", Instruction, 32'h0000_0013);
    chk("fmt7_err", {31'd0, OutError}, 32'd1);
    chk("errcnt_1", {24'd0, ErrorCount}, 32'd1);
    step(1'b0, 1'b1);
    push(3'd0, 3'd1, 1'b1, 5'd1, 5'd1, 5'd1, 32'd0); // OP alt with SLL
    chk("op_alt_err", {31'd0, OutError}, 32'd1);
    step(1'b0, 1'b1);
    push(3'd5, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0); // JALR funct3!=0
    chk("jalr_f3_err", {31'd0, OutError}, 32'd1);
    step(1'b0, 1'b1);
    push(3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8); // BRANCH funct3=010
    chk("br_f3_word", Instruction, 32'h0000_0013);
    chk("errcnt_4", {24'd0, ErrorCount}, 32'd4);
    step(1'b0, 1'b1);

    // Legal variants
    push(3'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3); // SRAI x1,x2,3
    chk("srai_word", Instruction, 32'h4031_5093);
    chk("srai_err", {31'd0, OutError}, 32'd0);
    step(1'b0, 1'b1);
    push(3'd5, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC); // JALR x1,-4(x2)
    chk("jalr_word", Instruction, 32'hFFC1_00E7);
    step(1'b0, 1'b1);
    push(3'd3, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 32'd16); // BNE x3,x4,+16
    chk("bne_word", Instruction, 32'h0041_9863);
    step(1'b0, 1'b1);

    // Immediate range handling
    push(3'd1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0000_0403); // SLLI, junk upper bits
`ifdef ENCODER_RANGE_CHECK_EN
    chk("slli_rng_word", Instruction, 32'h0000_0013);
    chk("slli_rng_err", {31'd0, OutError}, 32'd1);
`else
    chk("slli_rng_word", Instruction, 32'h0031_1093);
    chk("slli_rng_err", {31'd0, OutError}, 32'd0);
`endif
    step(1'b0, 1'b1);
    push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800); // ADDI imm 0x800
`ifdef ENCODER_RANGE_CHECK_EN
    chk("addi800_word", Instruction, 32'h0000_0013);
    chk("addi800_err", {31'd0, OutError}, 32'd1);
`else
    chk("addi800_word", Instruction, 32'h8000_0093);
    chk("addi800_err", {31'd0, OutError}, 32'd0);
`endif
    step(1'b0, 1'b1);

    // Saturation: flood with error words while draining every cycle
    @(negedge clk);
    set_fields(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    InValid = 1'b1; OutReady = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    InValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("errcnt_sat", {24'd0, ErrorCount}, 32'd255);
    chk("flood_drained", {31'd0, OutValid}, 32'd0);
    @(negedge clk); OutReady = 1'b0;

    // Reset mid-operation flushes the FIFO
    push(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7);
    push(3'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd8);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid", {31'd0, OutValid}, 32'd0);
    chk("flush_instr", Instruction, 32'd0);
    chk("flush_errcnt", {24'd0, ErrorCount}, 32'd0);
    chk("flush_enccnt", {16'd0, EncodedCount}, 32'd0);
    chk("flush_inready", {31'd0, InReady}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("flush_inready_rel", {31'd0, InReady}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
